// File: rtl/multicycle_sequencer.sv
// Opcode-driven control FSM for the multi-cycle RV32I core: owns the PC, the retired
// instruction counter and the memory wait timer, and traps on illegal opcodes or bus timeout.
module multicycle_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             take_branch,
  input  logic [XLEN-1:0]  target_addr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_is_fetch,
  output logic             ir_load,
  output logic             ex_en,
  output logic             reg_we,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       trap_cause
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_COMMIT    = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd7;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int unsigned WAIT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STALL_LIMIT);
  localparam bit TIMEOUT_ON = (STALL_LIMIT > 0);

  logic [2:0]        next_state;
  logic [1:0]        next_cause;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem_state;
  logic              timeout;

  assign in_mem_state = (state == S_FETCH) || (state == S_MEMORY);
  // A ready on the limit cycle completes the transfer, so timeout requires !mem_ready.
  assign timeout = TIMEOUT_ON && in_mem_state && !mem_ready && (wait_cnt == LIMIT);

  always_comb begin
    next_state = state;
    next_cause = trap_cause;
    case (state)
      S_FETCH: begin
        if (mem_ready) next_state = S_DECODE;
        else if (timeout) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
          OP_LOAD, OP_STORE, OP_BRANCH: next_state = S_EXECUTE;
          OP_FENCE:                     next_state = S_COMMIT;
          default: begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXECUTE: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) next_state = S_MEMORY;
        else if (opcode == OP_BRANCH)                next_state = S_COMMIT;
        else                                         next_state = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ready) next_state = (opcode == OP_LOAD) ? S_WRITEBACK : S_COMMIT;
        else if (timeout) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: next_state = S_COMMIT;
      S_COMMIT:    next_state = S_FETCH;
      default:     next_state = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_VECTOR;
      instret    <= '0;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      state      <= next_state;
      trap_cause <= next_cause;
      // Counter runs only while parked in the same memory state; any exit or ready clears it.
      if (in_mem_state && !mem_ready && next_state == state) wait_cnt <= wait_cnt + 1'b1;
      else                                                   wait_cnt <= '0;
      if (state == S_COMMIT) begin
        pc      <= take_branch ? target_addr : pc + XLEN'(4);
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_load      = 1'b0;
    ex_en        = 1'b0;
    reg_we       = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          ir_load      = mem_ready;
        end
        S_EXECUTE:   ex_en = 1'b1;
        S_MEMORY: begin
          mem_req = 1'b1;
          mem_we  = (opcode == OP_STORE);
        end
        S_WRITEBACK: reg_we = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (STALL_LIMIT=4): instruction flows, stalls,
// traps and reset behaviour, checked cycle by cycle against hand-computed values.
module tb_multicycle_sequencer;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        take_branch;
  logic [31:0] target_addr;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_is_fetch;
  logic        ir_load;
  logic        ex_en;
  logic        reg_we;
  logic [31:0] pc;
  logic [31:0] instret;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  trap_cause;

  int checks = 0;
  int failures = 0;

  multicycle_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h0), .STALL_LIMIT(4), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .take_branch(take_branch),
    .target_addr(target_addr), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_is_fetch(mem_is_fetch), .ir_load(ir_load),
    .ex_en(ex_en), .reg_we(reg_we), .pc(pc), .instret(instret),
    .state(state), .halted(halted), .trap_cause(trap_cause)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle's state/strobes/pc, then advance past the next clock edge.
  task automatic step(input string tag, input logic [2:0] es, input logic ereq,
                      input logic ewe, input logic ereg, input logic [31:0] epc);
    #1;
    chk({tag, ".state"},   {29'd0, state}, {29'd0, es});
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, ereq});
    chk({tag, ".mem_we"},  {31'd0, mem_we},  {31'd0, ewe});
    chk({tag, ".reg_we"},  {31'd0, reg_we},  {31'd0, ereg});
    chk({tag, ".pc"},      pc, epc);
    tick();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0110011; take_branch = 1'b0;
    target_addr = 32'h0; mem_ready = 1'b1;
    #1;
    chk("rst_hi.mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("rst_hi.mem_is_fetch", {31'd0, mem_is_fetch}, 32'd0);
    chk("rst_hi.ir_load", {31'd0, ir_load}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.state", {29'd0, state}, 32'd0);
    chk("rst.pc", pc, 32'h0);
    chk("rst.instret", instret, 32'd0);
    chk("rst.cause", {30'd0, trap_cause}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);

    // ALU op, zero-wait memory: 0,1,2,4,5
    chk("alu.ir_load", {31'd0, ir_load}, 32'd1);
    chk("alu.fetch", {31'd0, mem_is_fetch}, 32'd1);
    step("alu0", 3'd0, 1, 0, 0, 32'h0);
    step("alu1", 3'd1, 0, 0, 0, 32'h0);
    #1 chk("alu.ex_en", {31'd0, ex_en}, 32'd1);
    step("alu2", 3'd2, 0, 0, 0, 32'h0);
    step("alu3", 3'd4, 0, 0, 1, 32'h0);
    step("alu4", 3'd5, 0, 0, 0, 32'h0);
    chk("alu.pc", pc, 32'h4);
    chk("alu.instret", instret, 32'd1);

    // load with 3 wait cycles in MEMORY: 9 cycles
    opcode = 7'b0000011;
    step("ld0", 3'd0, 1, 0, 0, 32'h4);
    step("ld1", 3'd1, 0, 0, 0, 32'h4);
    step("ld2", 3'd2, 0, 0, 0, 32'h4);
    mem_ready = 1'b0;
    step("ld3", 3'd3, 1, 0, 0, 32'h4);
    #1 chk("ld.mem_is_fetch", {31'd0, mem_is_fetch}, 32'd0);
    step("ld4", 3'd3, 1, 0, 0, 32'h4);
    step("ld5", 3'd3, 1, 0, 0, 32'h4);
    mem_ready = 1'b1;
    step("ld6", 3'd3, 1, 0, 0, 32'h4);
    step("ld7", 3'd4, 0, 0, 1, 32'h4);
    step("ld8", 3'd5, 0, 0, 0, 32'h4);
    chk("ld.pc", pc, 32'h8);
    chk("ld.instret", instret, 32'd2);

    // store: mem_we only in MEMORY
    opcode = 7'b0100011;
    step("st0", 3'd0, 1, 0, 0, 32'h8);
    step("st1", 3'd1, 0, 0, 0, 32'h8);
    step("st2", 3'd2, 0, 0, 0, 32'h8);
    step("st3", 3'd3, 1, 1, 0, 32'h8);
    step("st4", 3'd5, 0, 0, 0, 32'h8);
    chk("st.pc", pc, 32'hC);

    // fence: 3 cycles, brings pc to 0x10
    opcode = 7'b0001111;
    step("fn0", 3'd0, 1, 0, 0, 32'hC);
    step("fn1", 3'd1, 0, 0, 0, 32'hC);
    step("fn2", 3'd5, 0, 0, 0, 32'hC);
    chk("fn.pc", pc, 32'h10);
    chk("fn.instret", instret, 32'd4);

    // taken branch; take_branch held high early must not move pc before COMMIT
    opcode = 7'b1100011; take_branch = 1'b1; target_addr = 32'h4;
    step("br0", 3'd0, 1, 0, 0, 32'h10);
    step("br1", 3'd1, 0, 0, 0, 32'h10);
    step("br2", 3'd2, 0, 0, 0, 32'h10);
    step("br3", 3'd5, 0, 0, 0, 32'h10);
    chk("br.pc", pc, 32'h4);
    chk("br.instret", instret, 32'd5);
    take_branch = 1'b0;

    // fetch timeout: 4 counting cycles, trap on the limit cycle
    opcode = 7'b0110011; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("to_wait", 3'd0, 1, 0, 0, 32'h4);
    #1;
    chk("to.state", {29'd0, state}, 32'd7);
    chk("to.halted", {31'd0, halted}, 32'd1);
    chk("to.cause", {30'd0, trap_cause}, 32'd2);
    mem_ready = 1'b1; take_branch = 1'b1;
    step("to_stick0", 3'd7, 0, 0, 0, 32'h4);
    step("to_stick1", 3'd7, 0, 0, 0, 32'h4);
    chk("to.instret", instret, 32'd5);

    // reset out of TRAP; strobes forced low while reset still high in FETCH
    take_branch = 1'b0; reset = 1'b1;
    tick();
    chk("rst2.state", {29'd0, state}, 32'd0);
    chk("rst2.mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst2.pc", pc, 32'h0);
    chk("rst2.cause", {30'd0, trap_cause}, 32'd0);
    chk("rst2.instret", instret, 32'd0);

    // ready arriving on the limit cycle wins
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("lim_wait", 3'd0, 1, 0, 0, 32'h0);
    mem_ready = 1'b1;
    step("lim_hit", 3'd0, 1, 0, 0, 32'h0);
    chk("lim.cause", {30'd0, trap_cause}, 32'd0);
    step("lim1", 3'd1, 0, 0, 0, 32'h0);
    step("lim2", 3'd2, 0, 0, 0, 32'h0);
    step("lim3", 3'd4, 0, 0, 1, 32'h0);
    step("lim4", 3'd5, 0, 0, 0, 32'h0);
    chk("lim.pc", pc, 32'h4);

    // reset in WRITEBACK aborts: no reg_we, no pc update
    step("ab0", 3'd0, 1, 0, 0, 32'h4);
    step("ab1", 3'd1, 0, 0, 0, 32'h4);
    step("ab2", 3'd2, 0, 0, 0, 32'h4);
    reset = 1'b1;
    #1 chk("ab.reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("ab.pc", pc, 32'h0);
    chk("ab.instret", instret, 32'd0);

    // illegal opcode traps after DECODE, pc frozen
    opcode = 7'b1111111;
    step("il0", 3'd0, 1, 0, 0, 32'h0);
    step("il1", 3'd1, 0, 0, 0, 32'h0);
    step("il2", 3'd7, 0, 0, 0, 32'h0);
    step("il3", 3'd7, 0, 0, 0, 32'h0);
    chk("il.cause", {30'd0, trap_cause}, 32'd1);
    chk("il.halted", {31'd0, halted}, 32'd1);
    chk("il.ex_en", {31'd0, ex_en}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("il_rst.state", {29'd0, state}, 32'd0);
    chk("il_rst.halted", {31'd0, halted}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised control sequencer for the multi-cycle RV32I core; replaces the fixed 11-step stage counter with an opcode-driven FSM.
- The FSM visits only the states an instruction needs.
- Waits on a ready/valid memory handshake, owns the PC register and a retired-instruction counter, and traps on illegal opcodes or memory timeout.
- Sits between the memory block, the decoder/register file/ALU datapath and the PC logic.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- STALL_LIMIT, 16, max cycles waiting for mem_ready before a bus-timeout trap; 0 disables the timeout.
- CNT_W, 32, width of instret counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction opcode from decoder; valid in DECODE and later states.
- take_branch  in  1  datapath: redirect PC (taken branch, jal, jalr); sampled in COMMIT.
- target_addr  in  XLEN  redirect target; sampled in COMMIT.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write (store in MEMORY).
- mem_is_fetch  out  1  request is an instruction fetch (address = pc).
- ir_load  out  1  latch instruction register.
- ex_en  out  1  latch operands/ALU/compare results.
- reg_we  out  1  register file write strobe.
- pc  out  XLEN  current PC.
- instret  out  CNT_W  retired-instruction count.
- state  out  3  FSM state encoding, for debug.
- halted  out  1  in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout.

Behaviour:
- Reset, while high and in the following cycle:
  - state=FETCH, pc=RESET_VECTOR, instret=0, trap_cause=00, wait counter=0.
  - While reset is high, all strobes (mem_req, mem_we, mem_is_fetch, ir_load, ex_en, reg_we) are forced 0.
  - Reset mid-operation aborts the instruction, with no reg_we or PC update.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, COMMIT=5, TRAP=7.
- Strobes are decoded from the registered state and mem_ready.
- FETCH:
  - mem_req=1, mem_is_fetch=1, mem_we=0.
  - ir_load = mem_ready.
  - On mem_ready → DECODE.
- DECODE:
  - Opcode classes:
    - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 → EXECUTE.
    - 0000011, 0100011 → EXECUTE.
    - 1100011 → EXECUTE.
    - 0001111 (fence) → COMMIT, treated as NOP.
  - Any other opcode → TRAP, cause 01.
- EXECUTE:
  - ex_en=1 for one cycle.
  - Load/store → MEMORY.
  - Branch → COMMIT.
  - All others → WRITEBACK.
- MEMORY:
  - mem_req=1, mem_is_fetch=0, mem_we=1 for store opcode 0100011.
  - On mem_ready: load → WRITEBACK, store → COMMIT.
- WRITEBACK: reg_we=1 for exactly one cycle → COMMIT.
- COMMIT:
  - pc <= take_branch ? target_addr : pc+4, modulo 2^XLEN.
  - instret <= instret+1, wrapping at 2^CNT_W.
  - → FETCH.
- TRAP:
  - Sticky: halted=1, all strobes 0, pc and instret frozen.
  - Exit only via reset.
- Wait counter:
  - Cleared on entry to FETCH/MEMORY and whenever mem_ready=1.
  - Increments each FETCH/MEMORY cycle with mem_ready=0.
  - If STALL_LIMIT>0 and the counter reaches STALL_LIMIT with mem_ready still 0 → TRAP, cause 10.
  - mem_ready in the same cycle the limit is hit wins: the transfer completes and there is no trap.
- mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory (mem_ready=1 on first request cycle), in cycles per instruction:
  - ALU/lui/auipc/jal/jalr: 5.
  - Load: 6.
  - Store: 5.
  - Branch: 4.
  - Fence: 3.
- Each memory wait cycle adds 1.
- take_branch and target_addr are ignored outside COMMIT.

Test Plan:
- Reset, then add opcode 0110011, mem_ready tied 1 → states 0,1,2,4,5,0. reg_we high exactly at cycle 4. pc 0→4. instret 0→1.
- Load 0000011 with mem_ready low 3 cycles in MEMORY → 9 cycles total, one reg_we, mem_we=0 throughout.
- Store 0100011 → mem_we=1 only in MEMORY, reg_we never asserted, pc+4.
- Branch 1100011 at pc=0x10, take_branch=1, target_addr=0x4 → 4 cycles, pc=0x4, no reg_we.
- Opcode 7'b1111111 → TRAP after DECODE, halted=1, trap_cause=01, pc unchanged, strobes 0 until reset; reset → pc=RESET_VECTOR, FETCH.
- STALL_LIMIT=4 with mem_ready held 0 in FETCH → TRAP, cause 10. Repeat with mem_ready=1 on the limit cycle → DECODE, no trap.
